// File: rtl/fft_quad_frame_ctrl.sv
// Frame controller for four parallel FFT lanes: gates the quad-sample stream into
// whole FFT frames, tracks frames in/out, and checks the returning bin index.
module fft_quad_frame_ctrl #(
  parameter int LOG2_NPT = 14,
  parameter int FCNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [FCNT_W-1:0]   num_frames,
  input  logic                in_valid,
  input  logic                fft_ready,
  output logic                fft_valid,
  output logic                fft_tlast,
  input  logic                out_valid,
  input  logic [LOG2_NPT-1:0] out_k,
  output logic                out_tlast,
  output logic                busy,
  output logic                done,
  output logic [FCNT_W-1:0]   frames_in,
  output logic [FCNT_W-1:0]   frames_out,
  output logic                drop_err,
  output logic                k_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [LOG2_NPT-1:0] LAST_BIN = '1;
  localparam logic [LOG2_NPT-1:0] K_ONE    = LOG2_NPT'(1);
  localparam logic [FCNT_W-1:0]   F_ONE    = FCNT_W'(1);

  state_t              state, state_nxt;
  logic [LOG2_NPT-1:0] sample_cnt;
  logic [LOG2_NPT-1:0] exp_k;
  logic [FCNT_W-1:0]   nf_q;
  logic [FCNT_W-1:0]   frames_in_inc;
  logic                stop_pend;
  logic                start_acc;
  logic                term;
  logic                flushed;

  // The source cannot stall, so a sample is accepted only when every lane is ready.
  assign fft_valid     = in_valid && fft_ready && (state == RUN) && !reset;
  assign fft_tlast     = fft_valid && (sample_cnt == LAST_BIN);
  assign out_tlast     = out_valid && (out_k == LAST_BIN);
  assign frames_in_inc = frames_in + F_ONE;
  assign flushed       = (frames_out == frames_in);
  assign busy          = (state != IDLE);
  assign done          = (state == FLUSH) && flushed && !reset;

  // A stop arriving on the final sample still ends the run after that frame.
  assign term = stop_pend || stop || ((nf_q != '0) && (frames_in_inc == nf_q));

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fft_tlast && term) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flushed) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      exp_k      <= '0;
      nf_q       <= '0;
      frames_in  <= '0;
      frames_out <= '0;
      stop_pend  <= 1'b0;
      drop_err   <= 1'b0;
      k_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        sample_cnt <= '0;
        exp_k      <= '0;
        nf_q       <= num_frames;
        frames_in  <= '0;
        frames_out <= '0;
        stop_pend  <= stop;
        drop_err   <= 1'b0;
        k_err      <= 1'b0;
      end else begin
        if (fft_valid) sample_cnt <= sample_cnt + K_ONE;
        if (fft_tlast) frames_in <= frames_in_inc;
        if (state_nxt == IDLE)          stop_pend <= 1'b0;
        else if (state == RUN && stop)  stop_pend <= 1'b1;
        if (in_valid && !fft_ready && state == RUN) drop_err <= 1'b1;
        // Both the in-order and the resync case expect out_k+1 next.
        if (out_valid) begin
          if (out_k != exp_k) k_err <= 1'b1;
          exp_k <= out_k + K_ONE;
        end
        if (out_tlast && state != IDLE) frames_out <= frames_out + F_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fft_quad_frame_ctrl.sv
// Directed bench for fft_quad_frame_ctrl with 8-bin frames: table of capture runs
// plus hand sequences for reset, bin-index errors and ignored starts.
module tb_fft_quad_frame_ctrl;
  localparam int LOG2_NPT = 3;
  localparam int FCNT_W   = 16;

  logic        clk = 1'b0;
  logic        reset, start, stop, in_valid, fft_ready, out_valid;
  logic [15:0] num_frames;
  logic [2:0]  out_k;
  logic        fft_valid, fft_tlast, out_tlast, busy, done, drop_err, k_err;
  logic [15:0] frames_in, frames_out;

  int errs   = 0;
  int checks = 0;

  fft_quad_frame_ctrl #(.LOG2_NPT(LOG2_NPT), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_frames(num_frames),
    .in_valid(in_valid), .fft_ready(fft_ready), .fft_valid(fft_valid), .fft_tlast(fft_tlast),
    .out_valid(out_valid), .out_k(out_k), .out_tlast(out_tlast), .busy(busy), .done(done),
    .frames_in(frames_in), .frames_out(frames_out), .drop_err(drop_err), .k_err(k_err)
  );

  always #5 clk = ~clk;

  // stop_at/gap_at are accepted-sample indices (255 = never, 254 = stop with start)
  typedef struct {
    int nf; int stop_at; int gap_at; int gap_len;
    int nv; int nt; int fin; int drop;
  } row_t;
  row_t rows[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input row_t r);
    int acc, nv, nt, gap;
    bit stop_sent;
    start = 1'b1; num_frames = 16'(r.nf); stop = (r.stop_at == 254);
    in_valid = 1'b0; fft_ready = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    acc = 0; nv = 0; nt = 0; gap = 0; stop_sent = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = 1'b1;
      fft_ready = !(acc == r.gap_at && gap < r.gap_len);
      if (!fft_ready) gap++;
      stop = (acc == r.stop_at) && !stop_sent;
      if (stop) stop_sent = 1;
      #1;
      if (fft_valid) begin
        nv++;
        if (fft_tlast) begin
          nt++;
          chk("tlast_pos", acc % 8, 7);
        end
        acc++;
      end else if (fft_tlast) begin
        chk("tlast_without_valid", 1, 0);
      end
      tick();
    end
    in_valid = 1'b0; stop = 1'b0; fft_ready = 1'b1;
    #1;
    chk("n_fft_valid", nv, r.nv);
    chk("n_fft_tlast", nt, r.nt);
    chk("frames_in", frames_in, r.fin);
    chk("drop_err", drop_err, r.drop);
    chk("busy_flush", busy, 1);
    chk("done_early", done, 0);
    for (int f = 0; f < r.fin; f++) begin
      for (int k = 0; k < 8; k++) begin
        out_valid = 1'b1; out_k = 3'(k);
        #1;
        chk("out_tlast", out_tlast, (k == 7) ? 1 : 0);
        chk("done_during_out", done, 0);
        tick();
      end
    end
    out_valid = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("frames_out", frames_out, r.fin);
    chk("k_err_clean", k_err, 0);
    tick();
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  initial begin
    rows[0] = '{2, 255, 255, 0, 16, 2, 2, 0};
    rows[1] = '{0,   3, 255, 0,  8, 1, 1, 0};
    rows[2] = '{1, 255,   3, 2,  8, 1, 1, 1};
    rows[3] = '{3,  10, 255, 0, 16, 2, 2, 0};
    rows[4] = '{0, 254, 255, 0,  8, 1, 1, 0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; num_frames = '0;
    in_valid = 1'b1; fft_ready = 1'b1; out_valid = 1'b0; out_k = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fft_valid", fft_valid, 0);
    chk("rst_frames_in", frames_in, 0);
    chk("rst_frames_out", frames_out, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_k_err", k_err, 0);
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    chk("idle_no_valid", fft_valid, 0);
    in_valid = 1'b0;

    // bin index 0,1,3,4,5,6,7 in IDLE: error at 3 only, no frame counted
    begin
      int ks[7];
      ks = '{0, 1, 3, 4, 5, 6, 7};
      for (int i = 0; i < 7; i++) begin
        out_valid = 1'b1; out_k = 3'(ks[i]);
        #1;
        chk("idle_out_tlast", out_tlast, (ks[i] == 7) ? 1 : 0);
        tick();
        chk("k_err_seq", k_err, (i >= 2) ? 1 : 0);
      end
      out_valid = 1'b0;
      chk("idle_frames_out", frames_out, 0);
      chk("idle_busy", busy, 0);
    end

    for (int i = 0; i < 5; i++) run_row(rows[i]);

    // reset in the middle of a frame, then a fresh one-frame run with an ignored start
    begin
      int nv, nt, acc;
      start = 1'b1; num_frames = 16'd0; tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; fft_ready = 1'b1; tick();
      end
      reset = 1'b1;
      #1;
      chk("rst_cycle_fft_valid", fft_valid, 0);
      chk("rst_cycle_fft_tlast", fft_tlast, 0);
      chk("rst_cycle_done", done, 0);
      tick();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_frames_in", frames_in, 0);
      chk("abort_fft_valid", fft_valid, 0);
      tick();
      start = 1'b1; num_frames = 16'd1; tick();
      start = 1'b0;
      nv = 0; nt = 0; acc = 0;
      for (int c = 0; c < 20; c++) begin
        in_valid = 1'b1;
        start = (c == 3);
        num_frames = 16'd0;
        #1;
        if (fft_valid) begin
          nv++;
          if (fft_tlast) begin
            nt++;
            chk("restart_tlast_pos", acc, 7);
          end
          acc++;
        end
        tick();
      end
      start = 1'b0; in_valid = 1'b0;
      chk("restart_nvalid", nv, 8);
      chk("restart_ntlast", nt, 1);
      chk("restart_frames_in", frames_in, 1);
      chk("restart_busy", busy, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fft_quad_frame_ctrl.md
FFT_QUAD_FRAME_CTRL -- requirements
Module: fft_quad_frame_ctrl

Interface
REQ-001 SHALL have parameter LOG2_NPT, default 14: log2 of per-lane FFT points; also the width of k.
REQ-002 SHALL have parameter FCNT_W, default 16: width of the frame counters and of num_frames.
REQ-003 SHALL have port clk  in  1: single clock for all logic.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port start  in  1: one-cycle request to begin a capture run.
REQ-006 SHALL have port stop  in  1: one-cycle request to end the run after the current frame.
REQ-007 SHALL have port num_frames  in  FCNT_W: frames per run; 0 means continuous until stop; sampled on an accepted start.
REQ-008 SHALL have port in_valid  in  1: quad-sample source valid; the source cannot stall.
REQ-009 SHALL have port fft_ready  in  1: AND of the four FFT lane s_axis_data_tready signals.
REQ-010 SHALL have port fft_valid  out  1: s_valid to the four FFT lanes.
REQ-011 SHALL have port fft_tlast  out  1: s_axis_data_tlast to all lanes.
REQ-012 SHALL have port out_valid  in  1: rotated-output valid (lane 0 CORDIC).
REQ-013 SHALL have port out_k  in  LOG2_NPT: bin index aligned with out_valid.
REQ-014 SHALL have port out_tlast  out  1: marks the last bin of an output frame.
REQ-015 SHALL have port busy  out  1: high whenever state is not IDLE.
REQ-016 SHALL have port done  out  1: one-cycle pulse when a run completes.
REQ-017 SHALL have ports frames_in and frames_out  out  FCNT_W: frames sent to the FFT and frames received from it.
REQ-018 SHALL have ports drop_err and k_err  out  1: sticky error flags.

Function
REQ-019 States SHALL be IDLE, RUN, FLUSH.
- IDLE -> RUN on start.
- RUN -> FLUSH at the end of the terminating frame.
- FLUSH -> IDLE when frames_out == frames_in.
REQ-020 In IDLE, start SHALL clear frames_in, frames_out, drop_err, k_err, sample_cnt and exp_k, and latch num_frames; start outside IDLE SHALL be ignored.
REQ-021 fft_valid SHALL equal in_valid AND fft_ready AND (state==RUN), combinationally, with zero latency.
REQ-022 sample_cnt (LOG2_NPT bits) SHALL increment on each fft_valid and wrap to 0 after 2^LOG2_NPT-1; fft_tlast = fft_valid AND sample_cnt==2^LOG2_NPT-1.
REQ-023 frames_in SHALL increment on each fft_valid&&fft_tlast cycle, wrapping modulo 2^FCNT_W.
REQ-024 A frame SHALL be terminating if a stop is pending, or if num_frames!=0 and frames_in+1==num_frames.
REQ-025 stop SHALL latch a pending flag; it never truncates a frame; stop in the same cycle as an accepted start yields exactly one frame.
REQ-026 drop_err SHALL set when in_valid=1, state==RUN and fft_ready=0; the sample is discarded and sample_cnt does not advance.
REQ-027 exp_k (LOG2_NPT bits) SHALL be checked on every out_valid cycle in any state:
- out_k != exp_k sets k_err and resyncs exp_k to out_k+1;
- otherwise exp_k increments, wrapping.
REQ-028 out_tlast SHALL equal out_valid AND out_k==2^LOG2_NPT-1, combinationally; frames_out increments on each out_tlast.
REQ-029 done SHALL pulse for exactly the cycle of the FLUSH->IDLE transition; the comparison uses registered counters, so done appears one cycle after the final out_tlast.
REQ-030 out_valid in IDLE SHALL update exp_k and k_err but SHALL NOT change frames_out.

Reset
REQ-031 On reset: state=IDLE; busy, done, drop_err, k_err, frames_in, frames_out, sample_cnt, exp_k and the stop-pending flag SHALL be 0; fft_valid and fft_tlast SHALL be 0 for that cycle.
REQ-032 reset asserted mid-RUN or mid-FLUSH SHALL abort immediately with no done pulse; partial frames are not counted.

Verification (LOG2_NPT=3, 8 bins)
REQ-033 num_frames=2, start, in_valid and fft_ready held high -> fft_tlast on samples 7 and 15; 16 fft_valid cycles; frames_in=2; state FLUSH.
REQ-034 Then out_k 0..7 twice -> out_tlast on each k=7; frames_out=2; done one cycle later; busy=0; k_err=0.
REQ-035 num_frames=0, stop at sample 3 -> samples continue to 7; fft_tlast at 7; frames_in=1; no further fft_valid.
REQ-036 fft_ready=0 for 2 cycles mid-frame with in_valid=1 -> drop_err=1; the frame still needs 8 accepted samples for fft_tlast.
REQ-037 out_k sequence 0,1,3,4 -> k_err=1 at k=3; no further error at k=4.
REQ-038 reset at sample 5 of a frame -> all outputs 0 next cycle; a new start produces fft_tlast after 8 samples.
